ext_mem_arbiter: RTL and testbench

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

---
 rtl/ext_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_ext_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - two-requester round-robin arbiter onto one external-memory LSU port
package SOPHON_PKG;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  amo;
    logic [3:0]  strb;
    logic [1:0]  size;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

endpackage

module ext_mem_arbiter
  import SOPHON_PKG::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  lsu_req_t lsu_req_m0_i,
  output lsu_ack_t lsu_ack_m0_o,
  input  lsu_req_t lsu_req_m1_i,
  output lsu_ack_t lsu_ack_m1_o,
  output lsu_req_t lsu_req_o,
  input  lsu_ack_t lsu_ack_i,
  output logic     timeout_o
);

  // A zero-width counter is illegal, so the timeout-disabled build keeps one inert bit.
  localparam int              LP_CW   = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LP_CW-1:0] LP_MAX  = '1;
  localparam logic             LP_TMO_EN = (TIMEOUT_CYCLES != 0);

  localparam lsu_req_t LP_REQ_IDLE = '{req: 1'b0, we: 1'b0, addr: '0, wdata: '0,
                                       amo: '0, strb: '0, size: 2'd1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  state_t           r_state;
  lsu_req_t         r_req;
  logic             r_last_grant;  // 0 = m0 served last, 1 = m1 served last
  logic [LP_CW-1:0] r_cnt;

  logic     w_busy;
  logic     w_ack_in;
  logic     w_tmo;
  logic     w_done;
  logic     w_grant_m1;
  logic     w_any_req;
  lsu_ack_t w_resp;

  assign w_busy     = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
  assign w_ack_in   = w_busy && lsu_ack_i.ack;
  // A real ack in the final cycle takes priority over the abort.
  assign w_tmo      = LP_TMO_EN && w_busy && !lsu_ack_i.ack && (r_cnt == LP_LAST);
  assign w_done     = w_ack_in || w_tmo;
  // m1 wins when alone, or when both request and m0 was the last one served.
  assign w_grant_m1 = lsu_req_m1_i.req && (!lsu_req_m0_i.req || !r_last_grant);
  assign w_any_req  = lsu_req_m0_i.req || lsu_req_m1_i.req;

  // Response to whichever requester owns the bus this cycle.
  always_comb begin
    w_resp = '0;
    if (w_ack_in) begin
      w_resp.ack   = 1'b1;
      w_resp.error = lsu_ack_i.error;
      w_resp.rdata = lsu_ack_i.rdata;
    end else if (w_tmo) begin
      w_resp.ack   = 1'b1;
      w_resp.error = 1'b1;
    end
  end

  assign lsu_ack_m0_o = (r_state == ST_BUSY0) ? w_resp : '0;
  assign lsu_ack_m1_o = (r_state == ST_BUSY1) ? w_resp : '0;
  assign lsu_req_o    = r_req;
  assign timeout_o    = w_tmo;

  // Grant FSM: captures the winner's request, holds it until ack or timeout, then returns idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_req        <= LP_REQ_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_req     <= w_grant_m1 ? lsu_req_m1_i : lsu_req_m0_i;
            r_req.req <= 1'b1;
            r_cnt     <= '0;
            r_state   <= w_grant_m1 ? ST_BUSY1 : ST_BUSY0;
          end
        end
        ST_BUSY0, ST_BUSY1: begin
          if (w_done) begin
            r_req        <= LP_REQ_IDLE;
            r_state      <= ST_IDLE;
            r_last_grant <= (r_state == ST_BUSY1);
          end else if (LP_TMO_EN && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + LP_CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= LP_REQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - self-checking bench for ext_mem_arbiter
module tb_ext_mem_arbiter;
  import SOPHON_PKG::*;

  localparam lsu_req_t RST_REQ = '{req: 1'b0, we: 1'b0, addr: '0, wdata: '0,
                                   amo: '0, strb: '0, size: 2'd1};

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  lsu_req_t m0 = '0;
  lsu_req_t m1 = '0;
  lsu_ack_t ack_in = '0;
  lsu_ack_t a0, a1, nt_a0, nt_a1;
  lsu_req_t req_o, nt_req;
  logic     tmo, nt_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_m0_i(m0), .lsu_ack_m0_o(a0),
    .lsu_req_m1_i(m1), .lsu_ack_m1_o(a1),
    .lsu_req_o(req_o), .lsu_ack_i(ack_in),
    .timeout_o(tmo)
  );

  ext_mem_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nt (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_m0_i(m0), .lsu_ack_m0_o(nt_a0),
    .lsu_req_m1_i(m1), .lsu_ack_m1_o(nt_a1),
    .lsu_req_o(nt_req), .lsu_ack_i(ack_in),
    .timeout_o(nt_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lsu_req_t rand_req();
    lsu_req_t r;
    r.req   = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.amo   = 5'($urandom_range(0, 31));
    r.strb  = 4'($urandom_range(0, 15));
    r.size  = 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; m0 = '0; m1 = '0; ack_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    m0 = rand_req(); m1 = rand_req();
    ack_in = '{ack: 1'b1, error: 1'b1, rdata: 32'hFFFF_FFFF};
    #2;
    n_checks++;
    if (req_o !== RST_REQ) begin n_fail++; $display("FAIL reset_req: got %h expected %h", req_o, RST_REQ); end
    n_checks++;
    if (a0 !== '0 || a1 !== '0) begin n_fail++; $display("FAIL reset_acks: got %h %h expected 0", a0, a1); end
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    m0 = '{req: 1'b1, we: 1'b0, addr: 32'h0009_0010, wdata: '0, amo: '0, strb: 4'hF, size: 2'd2};
    @(negedge clk);
    n_checks++;
    if (req_o.req !== 1'b0) begin n_fail++; $display("FAIL read_c1_req: got %b expected 0", req_o.req); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (c == 4) ack_in = '{ack: 1'b1, error: 1'b0, rdata: 32'hDEAD_BEEF};
      @(negedge clk);
      n_checks++;
      if (req_o.req !== 1'b1 || req_o.addr !== 32'h0009_0010) begin
        n_fail++; $display("FAIL read_c%0d_req: got req=%b addr=%h expected 1 00090010", c, req_o.req, req_o.addr);
      end
      n_checks++;
      if (a0 !== ((c == 4) ? lsu_ack_t'({1'b1, 1'b0, 32'hDEAD_BEEF}) : lsu_ack_t'(0)) || a1 !== '0) begin
        n_fail++; $display("FAIL read_c%0d_ack: got m0=%h m1=%h", c, a0, a1);
      end
    end
    tick();
    m0 = '0; ack_in = '0;
    @(negedge clk);
    n_checks++;
    if (req_o !== RST_REQ) begin n_fail++; $display("FAIL read_c5_req: got %h expected %h", req_o, RST_REQ); end
  endtask

  task automatic test_round_robin();
    lsu_req_t f[2];
    lsu_req_t exp_r;
    lsu_ack_t got;
    logic [31:0] rd;
    int w;
    apply_reset();
    f[0] = rand_req(); f[1] = rand_req();
    for (int i = 0; i < 6; i++) begin
      m0 = f[0]; m1 = f[1];
      @(negedge clk);
      n_checks++;
      if (req_o.req !== 1'b0) begin n_fail++; $display("FAIL rr%0d_idle: got req=%b expected 0", i, req_o.req); end
      tick();
      w = i % 2;
      rd = $urandom;
      ack_in = '{ack: 1'b1, error: 1'b0, rdata: rd};
      @(negedge clk);
      exp_r = f[w];
      n_checks++;
      if (req_o !== exp_r) begin n_fail++; $display("FAIL rr%0d_grant: got %h expected m%0d %h", i, req_o, w, exp_r); end
      got = (w == 1) ? a1 : a0;
      n_checks++;
      if (got !== lsu_ack_t'({1'b1, 1'b0, rd}) || ((w == 1) ? a0 : a1) !== '0) begin
        n_fail++; $display("FAIL rr%0d_ack: got m0=%h m1=%h winner m%0d", i, a0, a1, w);
      end
      tick();
      ack_in = '0;
      f[w] = rand_req();
    end
    m0 = '0; m1 = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    apply_reset();
    m1 = rand_req();
    tick();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 8 && (a1 !== '0 || tmo !== 1'b0)) begin
        n_fail++; $display("FAIL tmo_early%0d: got ack=%h tmo=%b expected 0", k, a1, tmo);
      end else if (k == 8 && (a1 !== lsu_ack_t'({1'b1, 1'b1, 32'h0}) || tmo !== 1'b1 || a0 !== '0)) begin
        n_fail++; $display("FAIL tmo_fire: got m1=%h m0=%h tmo=%b expected ack+err, tmo=1", a1, a0, tmo);
      end
      if (k == 8) begin
        n_checks++;
        if (nt_tmo !== 1'b0 || nt_a1 !== '0 || nt_a0 !== '0) begin
          n_fail++; $display("FAIL notmo_inert: got tmo=%b ack=%h expected 0", nt_tmo, nt_a1);
        end
      end
      tick();
    end
    m1 = '0;
    rd = $urandom;
    ack_in = '{ack: 1'b1, error: 1'b0, rdata: rd};
    @(negedge clk);
    n_checks++;
    if (req_o !== RST_REQ || a0 !== '0 || a1 !== '0) begin
      n_fail++; $display("FAIL tmo_stray: got req=%h m0=%h m1=%h expected idle, no acks", req_o, a0, a1);
    end
    n_checks++;
    if (nt_req.req !== 1'b1 || nt_a1 !== lsu_ack_t'({1'b1, 1'b0, rd}) || nt_tmo !== 1'b0) begin
      n_fail++; $display("FAIL notmo_complete: got req=%b ack=%h tmo=%b", nt_req.req, nt_a1, nt_tmo);
    end
    tick();
    ack_in = '0;
    @(negedge clk);
    n_checks++;
    if (req_o.req !== 1'b0 || tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_after_stray: got req=%b tmo=%b expected 0", req_o.req, tmo); end
  endtask

  task automatic test_ack_at_timeout();
    logic [31:0] rd;
    for (int e = 0; e < 2; e++) begin
      apply_reset();
      m0 = rand_req();
      tick();
      for (int k = 1; k < 8; k++) tick();
      rd = $urandom;
      ack_in = '{ack: 1'b1, error: 1'(e), rdata: rd};
      @(negedge clk);
      n_checks++;
      if (a0 !== lsu_ack_t'({1'b1, 1'(e), rd}) || tmo !== 1'b0) begin
        n_fail++; $display("FAIL ack_vs_tmo_e%0d: got ack=%h tmo=%b expected %h tmo=0", e, a0, tmo, {1'b1, 1'(e), rd});
      end
      tick();
      m0 = '0; ack_in = '0;
      @(negedge clk);
      n_checks++;
      if (req_o !== RST_REQ) begin n_fail++; $display("FAIL ack_vs_tmo_idle%0d: got %h expected %h", e, req_o, RST_REQ); end
    end
  endtask

  task automatic test_reset_mid_busy();
    lsu_req_t r;
    apply_reset();
    r = rand_req(); r.we = 1'b1; r.wdata = 32'h1234_5678;
    m0 = r;
    tick();
    @(negedge clk);
    n_checks++;
    if (req_o !== r) begin n_fail++; $display("FAIL rstbusy_pre: got %h expected %h", req_o, r); end
    tick();
    rst = 1'b1;
    ack_in = '{ack: 1'b1, error: 1'b0, rdata: 32'hCAFE_F00D};
    #2;
    n_checks++;
    if (req_o !== RST_REQ || a0 !== '0) begin n_fail++; $display("FAIL rstbusy_abort: got req=%h ack=%h expected cleared, no ack", req_o, a0); end
    tick();
    rst = 1'b0; m0 = '0; ack_in = '0;
    tick();
    r = rand_req();
    m0 = r;
    tick();
    ack_in = '{ack: 1'b1, error: 1'b0, rdata: 32'h0BAD_CAFE};
    @(negedge clk);
    n_checks++;
    if (req_o !== r || a0 !== lsu_ack_t'({1'b1, 1'b0, 32'h0BAD_CAFE})) begin
      n_fail++; $display("FAIL rstbusy_fresh: got req=%h ack=%h", req_o, a0);
    end
    tick();
    m0 = '0; ack_in = '0;
  endtask

  task automatic test_drop_req();
    lsu_req_t r;
    apply_reset();
    r = rand_req();
    m0 = r;
    tick();
    m0 = '0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) ack_in = '{ack: 1'b1, error: 1'b1, rdata: 32'h5555_AAAA};
      @(negedge clk);
      n_checks++;
      if (req_o !== r) begin n_fail++; $display("FAIL drop_hold%0d: got %h expected %h", k, req_o, r); end
      if (k == 3) begin
        n_checks++;
        if (a0 !== lsu_ack_t'({1'b1, 1'b1, 32'h5555_AAAA})) begin n_fail++; $display("FAIL drop_ack: got %h", a0); end
      end
      tick();
    end
    ack_in = '0;
  endtask

  // Transaction-level model: pending requesters, round-robin by last winner, ack or 8-cycle abort.
  task automatic test_random();
    logic     pend[2];
    lsu_req_t fld[2];
    lsu_req_t exp_r;
    lsu_ack_t exp_a, got_w, got_l;
    logic     last;
    logic     err;
    logic [31:0] rd;
    int w, ack_cyc;
    logic done_n, done_t;
    apply_reset();
    pend[0] = 1'b0; pend[1] = 1'b0; last = 1'b1;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin pend[i] = 1'b1; fld[i] = rand_req(); end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(0, 1); pend[w] = 1'b1; fld[w] = rand_req();
      end
      m0 = pend[0] ? fld[0] : '0;
      m1 = pend[1] ? fld[1] : '0;
      ack_in = '{ack: 1'($urandom_range(0, 1)), error: 1'($urandom_range(0, 1)), rdata: $urandom};
      @(negedge clk);
      n_checks++;
      if (req_o.req !== 1'b0 || a0 !== '0 || a1 !== '0) begin
        n_fail++; $display("FAIL rnd%0d_idle: got req=%b m0=%h m1=%h", it, req_o.req, a0, a1);
      end
      w = (pend[0] && pend[1]) ? int'(!last) : (pend[1] ? 1 : 0);
      ack_cyc = $urandom_range(1, 10);
      err = 1'($urandom_range(0, 1));
      rd = $urandom;
      tick();
      ack_in = '0;
      for (int k = 1; k <= 8; k++) begin
        if (k == ack_cyc) ack_in = '{ack: 1'b1, error: err, rdata: rd};
        @(negedge clk);
        done_n = (k == ack_cyc);
        done_t = (k == 8) && !done_n;
        exp_r = fld[w];
        exp_a = done_n ? lsu_ack_t'({1'b1, err, rd}) : (done_t ? lsu_ack_t'({1'b1, 1'b1, 32'h0}) : lsu_ack_t'(0));
        got_w = (w == 1) ? a1 : a0;
        got_l = (w == 1) ? a0 : a1;
        n_checks++;
        if (req_o !== exp_r || got_w !== exp_a || got_l !== '0 || tmo !== done_t) begin
          n_fail++;
          $display("FAIL rnd%0d_k%0d: req=%h exp %h, ack=%h exp %h, other=%h, tmo=%b exp %b",
                   it, k, req_o, exp_r, got_w, exp_a, got_l, tmo, done_t);
        end
        tick();
        ack_in = '0;
        if (done_n || done_t) break;
      end
      pend[w] = 1'b0;
      last = 1'(w);
    end
    m0 = '0; m1 = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_busy();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
